sipo_4b_loader: RTL and testbench

SIPO_4B_LOADER -- requirements
Module: sipo_4b_loader

---
 rtl/sipo_defs.sv | 18 +
 rtl/sipo_shreg.sv | 34 +++
 rtl/sipo_4b_loader.sv | 109 ++++++++++
 tb/tb_sipo_4b_loader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_defs.sv
// sipo_defs: shared widths and FSM encoding for sipo_4b_loader; SIPO_PARITY_EN adds one even-parity bit per word
package sipo_defs;
    localparam int DATA_W = 4;
    localparam int PAR_W  = 1;
`ifdef SIPO_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int NBITS = DATA_W + PAR_EN * PAR_W;
    localparam int CNT_W = $clog2(NBITS + 1);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        FIN   = 2'd3
    } state_t;
endpackage

// File: rtl/sipo_shreg.sv
// sipo_shreg: serial shift register with saturating bit counter; exposes the next word so the final bit can be loaded on its own edge
module sipo_shreg
    import sipo_defs::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             sdata,
    output logic [NBITS-1:0] sr_nxt,
    output logic             last
);
    logic [NBITS-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // shift direction follows MSB_FIRST; counter stops at the word length
    always_comb begin
        sr_nxt = (MSB_FIRST != 0) ? {sr_q[NBITS-2:0], sdata} : {sdata, sr_q[NBITS-1:1]};
        last   = shift_en && (cnt_q == CNT_W'(NBITS - 1));
        sr_d   = clr ? '0 : shift_en ? sr_nxt : sr_q;
        cnt_d  = clr ? '0 : (shift_en && cnt_q != CNT_W'(NBITS)) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sipo_4b_loader.sv
// sipo_4b_loader: receives a serial word and strobes it into a downstream 4-bit latch; SIPO_PARITY_EN enables parity checking
module sipo_4b_loader
    import sipo_defs::*;
#(
    parameter int MSB_FIRST     = 1,
    parameter int ENABLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sdata,
    input  logic              svalid,
    output logic [DATA_W-1:0] B,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] b_q, b_d, word;
    logic [2:0]        ecnt_q, ecnt_d;
    logic              enable_q, enable_d, busy_q, busy_d, done_q, done_d;
    logic [NBITS-1:0]  sr_nxt;
    logic              last, par_ok, clr, shift_en;

    sipo_shreg #(.MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_en),
        .sdata    (sdata),
        .sr_nxt   (sr_nxt),
        .last     (last)
    );

    // next-state and registered-output logic; B only changes on a good final-bit edge
    always_comb begin
        clr      = (state_q == IDLE) && start;
        shift_en = (state_q == SHIFT) && svalid;
        word     = (MSB_FIRST != 0) ? sr_nxt[NBITS-1 -: DATA_W] : sr_nxt[DATA_W-1:0];
`ifdef SIPO_PARITY_EN
        par_ok   = ~^sr_nxt;
`else
        par_ok   = 1'b1;
`endif
        state_d  = state_q;
        b_d      = b_q;
        ecnt_d   = ecnt_q;
        enable_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE:  state_d = start ? SHIFT : IDLE;
            SHIFT: if (last) begin
                state_d  = par_ok ? LOAD : FIN;
                b_d      = par_ok ? word : b_q;
                enable_d = par_ok;
                done_d   = !par_ok;
                ecnt_d   = 3'd1;
            end
            LOAD:  if (ecnt_q == 3'(ENABLE_CYCLES)) begin
                state_d = FIN;
                done_d  = 1'b1;
            end else begin
                enable_d = 1'b1;
                ecnt_d   = ecnt_q + 3'd1;
            end
            FIN:   state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // FSM state and all outputs, cleared asynchronously so a reset aborts at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            b_q      <= '0;
            ecnt_q   <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            ecnt_q   <= ecnt_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic err_q, err_d;
    // error set on a parity mismatch, held until the next accepted start
    always_comb err_d = clr ? 1'b0 : (shift_en && last && !par_ok) ? 1'b1 : err_q;
    // error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign B      = b_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_sipo_4b_loader.sv
// tb_sipo_4b_loader: scoreboard bench over three configurations (MSB/EC1, LSB/EC1, MSB/EC3); honours SIPO_PARITY_EN
module tb_sipo_4b_loader;
    import sipo_defs::*;

    typedef struct {
        logic [3:0] b;
        logic       err;
        int         en;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sdata = 1'b0, svalid = 1'b0;
    logic [2:0][3:0] b_o;
    logic [2:0]      en_o, busy_o, done_o, err_o;

    int n_run = 0, n_fail = 0;
    exp_t sb[3][$];
    logic [2:0][3:0] lastb = '0;
    logic [2:0][3:0] b_hold = '0;
    int en_cnt[3] = '{0, 0, 0};

    sipo_4b_loader #(.MSB_FIRST(1), .ENABLE_CYCLES(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .sdata(sdata), .svalid(svalid),
        .B(b_o[0]), .enable(en_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]));
    sipo_4b_loader #(.MSB_FIRST(0), .ENABLE_CYCLES(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .sdata(sdata), .svalid(svalid),
        .B(b_o[1]), .enable(en_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]));
    sipo_4b_loader #(.MSB_FIRST(1), .ENABLE_CYCLES(3)) u_ec3 (
        .clk(clk), .rst_n(rst_n), .start(start), .sdata(sdata), .svalid(svalid),
        .B(b_o[2]), .enable(en_o[2]), .busy(busy_o[2]), .done(done_o[2]), .err(err_o[2]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_b%0d", tag, i), b_o[i], 0);
            check($sformatf("%s_en%0d", tag, i), en_o[i], 0);
            check($sformatf("%s_busy%0d", tag, i), busy_o[i], 0);
            check($sformatf("%s_done%0d", tag, i), done_o[i], 0);
            check($sformatf("%s_err%0d", tag, i), err_o[i], 0);
        end
    endtask

    function automatic logic [3:0] rev(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic wait_idle();
        for (int t = 0; t < 20 && busy_o != 3'b000; t++) begin
            @(posedge clk); #1;
        end
        check("idle", busy_o, 3'b000);
    endtask

    // w[3] is sent first; gaps[k] idle cycles precede bit k; bad corrupts parity; poke raises start during LOAD
    task automatic send_word(input logic [3:0] w, input logic [4:0][2:0] gaps, input logic bad, input logic poke);
        logic [NBITS-1:0] bits;
        logic par_bad;
        exp_t e;
        par_bad = bad && (NBITS > DATA_W);
`ifdef SIPO_PARITY_EN
        bits = {w, ^w ^ par_bad};
`else
        bits = w;
`endif
        for (int i = 0; i < 3; i++) begin
            e.err = par_bad;
            e.en  = par_bad ? 0 : (i == 2 ? 3 : 1);
            e.b   = par_bad ? lastb[i] : (i == 1 ? rev(w) : w);
            lastb[i] = e.b;
            sb[i].push_back(e);
        end
        start = 1'b1; svalid = 1'b1; sdata = ~bits[NBITS-1];
        @(posedge clk); #1;
        start = 1'b0; svalid = 1'b0;
        check("busy_start", busy_o[0], 1);
        check("err_clr", err_o[0], 0);
        for (int k = 0; k < NBITS; k++) begin
            repeat (gaps[k]) begin
                sdata = 1'($urandom);
                @(posedge clk); #1;
            end
            svalid = 1'b1; sdata = bits[NBITS-1-k];
            @(posedge clk); #1;
            svalid = 1'b0;
        end
        if (par_bad) begin
            check("en_bad", en_o[0], 0);
            check("done_bad", done_o[0], 1);
        end else begin
            check("en_rise", en_o[0], 1);
            check("b_load", b_o[0], w);
            start = poke;
            @(posedge clk); #1;
            check("en_fall", en_o[0], 0);
            check("done", done_o[0], 1);
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_low", busy_o[0], 0);
        end
        start = 1'b0;
        wait_idle();
        @(posedge clk); #1;
    endtask

    // scoreboard side: counts enable cycles, checks B is steady while enabled, compares on done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    en_cnt[i] = 0;
                end else begin
                    if (en_o[i]) begin
                        if (en_cnt[i] > 0) check($sformatf("b_stable%0d", i), b_o[i], b_hold[i]);
                        b_hold[i] = b_o[i];
                        en_cnt[i]++;
                    end
                    if (done_o[i]) begin
                        if (sb[i].size() == 0) begin
                            check($sformatf("sb_empty%0d", i), 1, 0);
                        end else begin
                            e = sb[i].pop_front();
                            check($sformatf("sb_b%0d", i), b_o[i], e.b);
                            check($sformatf("sb_en%0d", i), en_cnt[i], e.en);
                            check($sformatf("sb_err%0d", i), err_o[i], e.err);
                        end
                        en_cnt[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0][2:0] g;
        #12;
        check_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        g = '0;
        send_word(4'b1011, g, 1'b0, 1'b0);
        send_word(4'b1000, g, 1'b0, 1'b0);
        g[1] = 3'd1; g[2] = 3'd2;
        send_word(4'b1011, g, 1'b0, 1'b0);
        g = '0;
        send_word(4'b0110, g, 1'b0, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; svalid = 1'b1; sdata = 1'b1;
        @(posedge clk); #1;
        sdata = 1'b0;
        @(posedge clk); #1;
        svalid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lastb = '0;
        @(posedge clk); #1;
        check("post_abort_b", b_o[0], 0);
        send_word(4'b1101, g, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        send_word(4'b1011, g, 1'b1, 1'b0);
        check("err_hold", err_o[0], 1);
        send_word(4'b1011, g, 1'b0, 1'b0);
`endif
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 5; k++) g[k] = 3'($urandom_range(0, 2));
            send_word(4'($urandom), g, 1'b0, 1'($urandom));
        end
        for (int i = 0; i < 3; i++) check($sformatf("sb_left%0d", i), sb[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
